slave_in_port: RTL

Slave-side receive port of the serial system bus. It accepts a master's request, performs the valid/ready handshake, and deserialises the LSB-first address and data bit streams into parallel words. It then issues a one-cycle write or read request to the attached slave memory. It sits between the bus interconnect (after slave-select decoding) and the slave's local memory/controller, and pairs with the slave's output port, which returns read data.

---
 rtl/slave_in_port_pkg.sv | 26 ++
 rtl/slave_in_port_if.sv | 30 +++
 rtl/slave_in_port_s2p.sv | 31 +++
 rtl/slave_in_port.sv | 132 +++++++++++++
 4 files changed

// File: rtl/slave_in_port_pkg.sv
// Shared serial-bus definitions: FSM state encoding, master command encoding
// and default word lengths for the slave receive port.
package slave_in_port_pkg;

    localparam int DEF_ADDR_LEN = 12;
    localparam int DEF_DATA_LEN = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RECEIVE   = 3'd1,
        ST_WRITE_OUT = 3'd2,
        ST_READ_OUT  = 3'd3,
        ST_READ_WAIT = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        CMD_INACTIVE = 2'b00,
        CMD_WRITE    = 2'b10,
        CMD_READ     = 2'b11
    } cmd_e;

    function automatic int max_len(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/slave_in_port_if.sv
// Bus-side signals between the interconnect (master view) and the slave
// receive port, plus the memory strobes and read-completion handshake.
interface slave_in_port_if #(
    parameter int ADDR_LEN = slave_in_port_pkg::DEF_ADDR_LEN,
    parameter int DATA_LEN = slave_in_port_pkg::DEF_DATA_LEN
);
    logic                selected;
    logic                master_valid;
    logic                write_en;
    logic                read_en;
    logic                rx_address;
    logic                rx_data;
    logic                read_done;
    logic                slave_ready;
    logic [ADDR_LEN-1:0] address;
    logic [DATA_LEN-1:0] data;
    logic                write_req;
    logic                read_req;
    logic                rx_done;

    modport slave (
        input  selected, master_valid, write_en, read_en, rx_address, rx_data, read_done,
        output slave_ready, address, data, write_req, read_req, rx_done
    );

    modport master (
        output selected, master_valid, write_en, read_en, rx_address, rx_data, read_done,
        input  slave_ready, address, data, write_req, read_req, rx_done
    );
endinterface

// File: rtl/slave_in_port_s2p.sv
// Shadow register that collects one serial bit per enabled cycle at a given
// index; exposes its next value so the caller can load the completed word.
module serial_to_parallel #(
    parameter int WIDTH = 8,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] word_d_o
);
    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_d;

    // Clear and capture may coincide: a new transfer starts with bit 0.
    always_comb begin
        word_d = clr_i ? '0 : word_q;
        if (en_i)
            word_d[idx_i] = bit_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) word_q <= '0;
        else       word_q <= word_d;
    end

    assign word_d_o = word_d;
endmodule

// File: rtl/slave_in_port.sv
// Slave receive port: handshake with the master, deserialise LSB-first
// address/data streams and issue a one-cycle write or read strobe.
module slave_in_port
    import slave_in_port_pkg::*;
#(
    parameter int ADDR_LEN = DEF_ADDR_LEN,
    parameter int DATA_LEN = DEF_DATA_LEN
) (
    input  logic          clk,
    input  logic          reset,
    slave_in_port_if.slave bus
);
    localparam int N     = max_len(ADDR_LEN, DATA_LEN);
    localparam int CNT_W = $clog2(N) + 1;
    localparam int AIW   = (ADDR_LEN > 1) ? $clog2(ADDR_LEN) : 1;
    localparam int DIW   = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;

    state_e             state_q, state_d;
    cmd_e               cmd_q, cmd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_LEN-1:0] address_q, addr_sh_d;
    logic [DATA_LEN-1:0] data_q, data_sh_d;
    logic               hs, abort, cap, cap_a, cap_d, last;

    // Being in IDLE is exactly slave_ready=1, so it stands in for the ready term.
    assign hs    = (state_q == ST_IDLE) && bus.selected && bus.master_valid
                   && (bus.write_en || bus.read_en);
    assign abort = (state_q == ST_RECEIVE) && !(bus.selected && bus.master_valid);
    assign cap   = hs || ((state_q == ST_RECEIVE) && !abort);
    assign cap_a = cap && (cnt_q < CNT_W'(ADDR_LEN));
    assign cap_d = cap && (cnt_q < CNT_W'(DATA_LEN));
    assign last  = (state_q == ST_RECEIVE) && !abort && (cnt_q == CNT_W'(N - 1));

    serial_to_parallel #(.WIDTH(ADDR_LEN), .IDX_W(AIW)) u_addr_s2p (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (hs),
        .en_i     (cap_a),
        .idx_i    (cnt_q[AIW-1:0]),
        .bit_i    (bus.rx_address),
        .word_d_o (addr_sh_d)
    );

    serial_to_parallel #(.WIDTH(DATA_LEN), .IDX_W(DIW)) u_data_s2p (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (hs),
        .en_i     (cap_d),
        .idx_i    (cnt_q[DIW-1:0]),
        .bit_i    (bus.rx_data),
        .word_d_o (data_sh_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_INACTIVE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    state_d = ST_RECEIVE;
                    cmd_d   = bus.read_en ? CMD_READ : CMD_WRITE;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_RECEIVE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    cmd_d   = CMD_INACTIVE;
                    cnt_d   = '0;
                end else if (last) begin
                    state_d = (cmd_q == CMD_READ) ? ST_READ_OUT : ST_WRITE_OUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WRITE_OUT: begin
                state_d = ST_IDLE;
                cmd_d   = CMD_INACTIVE;
                cnt_d   = '0;
            end
            ST_READ_OUT: state_d = ST_READ_WAIT;
            ST_READ_WAIT: begin
                if (bus.read_done) begin
                    state_d = ST_IDLE;
                    cmd_d   = CMD_INACTIVE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cmd_d   = CMD_INACTIVE;
                cnt_d   = '0;
            end
        endcase
    end

    // Strobes and ready are pure decodes of the state register.
    always_comb begin
        bus.slave_ready = (state_q == ST_IDLE);
        bus.write_req   = (state_q == ST_WRITE_OUT);
        bus.read_req    = (state_q == ST_READ_OUT);
        bus.rx_done     = (state_q == ST_WRITE_OUT) || (state_q == ST_READ_OUT);
    end

    // Reads still shift data bits but never disturb the last written word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            address_q <= '0;
            data_q    <= '0;
        end else if (last) begin
            address_q <= addr_sh_d;
            if (cmd_q == CMD_WRITE)
                data_q <= data_sh_d;
        end
    end

    assign bus.address = address_q;
    assign bus.data    = data_q;
endmodule
